// File: rtl/dodge_throw_ctrl.sv
// rtl/dodge_throw_ctrl.sv - ballistic trajectory engine driving the throw-sprite slot bus (option: THROW_SPIN_EN)
module dodge_throw_ctrl #(
    parameter int                 X_MAX    = 620,
    parameter int                 FLOOR_Y  = 448,
    parameter logic [5:0]         GRAV     = 6'd3,
    parameter logic signed [9:0]  VY_MAX   = 10'sd160,
    parameter logic [2:0]         COLOR    = 3'b001,
    parameter int                 SPIN_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        launch,
    input  logic [10:0] launch_x,
    input  logic [10:0] launch_y,
    input  logic [9:0]  launch_vx,
    input  logic [9:0]  launch_vy,
    output logic        cs,
    output logic        write,
    output logic [13:0] addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        landed
);

    typedef enum logic [3:0] {
        HIDE, IDLE, ARM, WAIT, UPDATE, WR_X, WR_Y, WR_CTRL, WR_SHOW
    } state_t;

    localparam logic [11:0]        X_LIM     = 12'(X_MAX);
    localparam logic [11:0]        FLOOR_LIM = 12'(FLOOR_Y);
    localparam logic signed [16:0] VY_LIM    = {{7{VY_MAX[9]}}, VY_MAX};

    state_t state, state_next;
    logic   run;
    logic   [14:0] px, py;
    logic   [9:0]  vx, vy;
    logic   first, pending, landed_q;
    logic   [1:0]  anim;

    logic signed [16:0] vy_sum, px_n, py_n;
    logic        [9:0]  vy_sat;
    logic               off_screen, on_floor, above_top, commit;

    // Physics step: all sums in 17-bit signed so out-of-range results stay visible.
    always_comb begin
        vy_sum     = $signed({{7{vy[9]}}, vy}) + $signed({11'd0, GRAV});
        vy_sat     = (vy_sum > VY_LIM) ? VY_MAX : vy_sum[9:0];
        px_n       = $signed({2'b00, px}) + $signed({{7{vx[9]}}, vx});
        py_n       = $signed({2'b00, py}) + $signed({{7{vy_sat[9]}}, vy_sat});
        off_screen = px_n[16] || (px_n[15:4] > X_LIM);
        on_floor   = !py_n[16] && (py_n[15:4] >= FLOOR_LIM);
        above_top  = py_n[16];
        commit     = (state == UPDATE) && !off_screen && !on_floor;
    end

    // run stays low through reset so the HIDE write waits for the first live cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= HIDE;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HIDE:    if (run) state_next = IDLE;
            IDLE:    if (launch) state_next = ARM;
            ARM:     if (frame_start) state_next = WR_X;
            WAIT:    if (frame_start || pending) state_next = UPDATE;
            UPDATE:  state_next = (off_screen || on_floor) ? HIDE : WR_X;
            WR_X:    state_next = WR_Y;
            WR_Y:    state_next = WR_CTRL;
            WR_CTRL: state_next = first ? WR_SHOW : WAIT;
            WR_SHOW: state_next = WAIT;
            default: state_next = HIDE;
        endcase
    end

    always_comb begin
        cs      = 1'b0;
        write   = 1'b0;
        addr    = 14'd0;
        wr_data = 32'd0;
        busy    = 1'b0;
        case (state)
            HIDE: if (run) begin
                cs = 1'b1; write = 1'b1; addr = 14'h2000; wr_data = 32'd1;
            end
            ARM, WAIT, UPDATE: busy = 1'b1;
            WR_X: begin
                busy = 1'b1; cs = 1'b1; write = 1'b1;
                addr = 14'h2001; wr_data = {21'd0, px[14:4]};
            end
            WR_Y: begin
                busy = 1'b1; cs = 1'b1; write = 1'b1;
                addr = 14'h2002; wr_data = {21'd0, py[14:4]};
            end
            WR_CTRL: begin
                busy = 1'b1; cs = 1'b1; write = 1'b1;
                addr = 14'h2003; wr_data = {27'd0, COLOR, anim};
            end
            WR_SHOW: begin
                busy = 1'b1; cs = 1'b1; write = 1'b1;
                addr = 14'h2000; wr_data = 32'd0;
            end
            default: ;
        endcase
    end

    assign landed = landed_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            px       <= '0;
            py       <= '0;
            vx       <= '0;
            vy       <= '0;
            first    <= 1'b0;
            pending  <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            landed_q <= 1'b0;
            // A frame tick seen mid-sequence is remembered once and replayed from WAIT.
            if (state == WAIT)
                pending <= 1'b0;
            else if (frame_start && state != ARM)
                pending <= 1'b1;
            case (state)
                IDLE: if (launch) begin
                    px    <= {launch_x, 4'b0000};
                    py    <= {launch_y, 4'b0000};
                    vx    <= launch_vx;
                    vy    <= launch_vy;
                    first <= 1'b1;
                end
                UPDATE: begin
                    if (off_screen) begin
                        // leave the flight untouched; HIDE takes over
                    end else if (on_floor) begin
                        py       <= {FLOOR_LIM[10:0], 4'b0000};
                        landed_q <= 1'b1;
                    end else if (above_top) begin
                        px <= px_n[14:0];
                        py <= '0;
                        vy <= '0;
                    end else begin
                        px <= px_n[14:0];
                        py <= py_n[14:0];
                        vy <= vy_sat;
                    end
                end
                WR_SHOW: first <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef THROW_SPIN_EN
    logic [7:0] spin_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            anim     <= 2'd0;
            spin_cnt <= 8'd0;
        end else if (state == IDLE && launch) begin
            anim     <= 2'd0;
            spin_cnt <= 8'd0;
        end else if (commit) begin
            if (spin_cnt == 8'(SPIN_DIV - 1)) begin
                spin_cnt <= 8'd0;
                anim     <= anim + 2'd1;
            end else begin
                spin_cnt <= spin_cnt + 8'd1;
            end
        end
    end
`else
    assign anim = 2'b00;
`endif

endmodule
